// File: rtl/instructions_pkg.sv
// -----------------------------------------------------------------------------
// instructions_pkg
// Shared RV32I decode definitions:
//   - inst_type_e   : supported major opcodes (R/I/S/B/U/J formats)
//   - *_fmt_t       : bit-field layouts of each instruction format
//   - instruction_t : packed union giving every format view of one 32-bit word
//   - decoded_t     : decoded bundle handed from decode to execute
//   - skid_state_e  : occupancy states of the two-entry skid buffer
//   - decode()      : combinational instruction decoder
// -----------------------------------------------------------------------------
package instructions_pkg;

    localparam int unsigned XLEN_C = 32;

    typedef enum logic [6:0] {
        r_type = 7'h33,   // OP
        i_type = 7'h13,   // OP-IMM
        s_type = 7'h23,   // STORE
        b_type = 7'h63,   // BRANCH
        u_type = 7'h17,   // AUIPC
        j_type = 7'h6F    // JAL
    } inst_type_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_fmt_t;

    typedef struct packed {
        logic [11:0] imm_11_0;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } i_fmt_t;

    typedef struct packed {
        logic [6:0] imm_11_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] imm_4_0;
        logic [6:0] opcode;
    } s_fmt_t;

    typedef struct packed {
        logic       imm_12;
        logic [5:0] imm_10_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm_4_1;
        logic       imm_11;
        logic [6:0] opcode;
    } b_fmt_t;

    typedef struct packed {
        logic [19:0] imm_31_12;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } u_fmt_t;

    typedef struct packed {
        logic       imm_20;
        logic [9:0] imm_10_1;
        logic       imm_11;
        logic [7:0] imm_19_12;
        logic [4:0] rd;
        logic [6:0] opcode;
    } j_fmt_t;

    typedef union packed {
        r_fmt_t      r;
        i_fmt_t      i;
        s_fmt_t      s;
        b_fmt_t      b;
        u_fmt_t      u;
        j_fmt_t      j;
        logic [31:0] raw;
    } instruction_t;

    typedef struct packed {
        logic [XLEN_C-1:0] pc;
        inst_type_e        itype;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [XLEN_C-1:0] imm;
        logic              illegal;
    } decoded_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Register indices and funct fields are passed through raw regardless of
    // format; only the immediate depends on the opcode. Unknown opcodes keep
    // their raw value in itype so downstream can report them.
    function automatic decoded_t decode(input instruction_t inst,
                                        input logic [XLEN_C-1:0] pc);
        decoded_t d;
        d.pc      = pc;
        d.itype   = inst_type_e'(inst.r.opcode);
        d.rd      = inst.r.rd;
        d.rs1     = inst.r.rs1;
        d.rs2     = inst.r.rs2;
        d.funct3  = inst.r.funct3;
        d.funct7  = inst.r.funct7;
        d.imm     = {XLEN_C{1'b0}};
        d.illegal = 1'b0;
        case (inst.r.opcode)
            7'h33: d.imm = {XLEN_C{1'b0}};
            7'h13: d.imm = {{20{inst.i.imm_11_0[11]}}, inst.i.imm_11_0};
            7'h23: d.imm = {{20{inst.s.imm_11_5[6]}}, inst.s.imm_11_5, inst.s.imm_4_0};
            7'h63: d.imm = {{19{inst.b.imm_12}}, inst.b.imm_12, inst.b.imm_11,
                            inst.b.imm_10_5, inst.b.imm_4_1, 1'b0};
            7'h17: d.imm = {inst.u.imm_31_12, 12'h000};
            7'h6F: d.imm = {{11{inst.j.imm_20}}, inst.j.imm_20, inst.j.imm_19_12,
                            inst.j.imm_11, inst.j.imm_10_1, 1'b0};
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/inst_skid_buffer.sv
// -----------------------------------------------------------------------------
// inst_skid_buffer
// Two-entry skid buffer with registered handshakes on both sides. The output
// register holds the oldest entry; the skid register catches one extra word
// when the consumer stalls, so in_ready can be registered and still allow
// full throughput.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   flush            synchronous clear of both entries (drops same-cycle input)
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
// -----------------------------------------------------------------------------
module inst_skid_buffer
    import instructions_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic [W-1:0] r_skid_data;

    logic w_accept;
    logic w_handoff;

    assign w_accept  = in_valid && r_in_ready && !flush;
    assign w_handoff = r_out_valid && out_ready;

    // Occupancy FSM; in_ready/out_valid are registered copies of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= {W{1'b0}};
            r_skid_data <= {W{1'b0}};
        end else if (flush) begin
            // Flush wins over any handoff or accept in the same cycle.
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_accept) begin
                        r_out_data  <= in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= SKID_ONE;
                    end else begin
                        r_state <= SKID_EMPTY;
                    end
                end
                SKID_ONE: begin
                    if (w_accept && w_handoff) begin
                        r_out_data <= in_data;
                    end else if (w_accept) begin
                        // Consumer stalled: park the new word behind the output.
                        r_skid_data <= in_data;
                        r_in_ready  <= 1'b0;
                        r_state     <= SKID_TWO;
                    end else if (w_handoff) begin
                        r_out_valid <= 1'b0;
                        r_state     <= SKID_EMPTY;
                    end else begin
                        r_state <= SKID_ONE;
                    end
                end
                SKID_TWO: begin
                    if (w_handoff) begin
                        r_out_data <= r_skid_data;
                        r_in_ready <= 1'b1;
                        r_state    <= SKID_ONE;
                    end else begin
                        r_state <= SKID_TWO;
                    end
                end
                default: begin
                    r_state     <= SKID_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: rtl/inst_decode_stage.sv
// -----------------------------------------------------------------------------
// inst_decode_stage
// RV32I decode stage between fetch and execute. Each fetched word is decoded
// combinationally, then the decoded bundle is stored in a two-entry skid
// buffer so fetch and execute can stall independently at one word per cycle.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   flush                    synchronous pipeline flush (branch redirect)
//   in_valid/in_ready        fetch handshake; in_inst/in_pc word and its PC
//   out_valid/out_ready      execute handshake
//   out_pc, out_type, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
//   out_imm, out_illegal     decoded bundle
//   illegal_cnt              saturating count of illegal bundles handed off
// -----------------------------------------------------------------------------
module inst_decode_stage
    import instructions_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  instruction_t     in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output inst_type_e       out_type,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    decoded_t         w_dec;
    decoded_t         w_out;
    logic             w_out_valid;
    logic             w_handoff;
    logic [CNT_W-1:0] r_illegal_cnt;

    assign w_dec = decode(in_inst, in_pc);

    inst_skid_buffer #(
        .W ($bits(decoded_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_dec),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_data  (w_out)
    );

    // A handoff during flush still counts as consumed by execute.
    assign w_handoff = w_out_valid && out_ready;

    // Saturating illegal-bundle counter; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= {CNT_W{1'b0}};
        end else if (w_handoff && w_out.illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_illegal_cnt <= r_illegal_cnt;
        end
    end

    assign out_valid   = w_out_valid;
    assign out_pc      = w_out.pc;
    assign out_type    = w_out.itype;
    assign out_rd      = w_out.rd;
    assign out_rs1     = w_out.rs1;
    assign out_rs2     = w_out.rs2;
    assign out_funct3  = w_out.funct3;
    assign out_funct7  = w_out.funct7;
    assign out_imm     = w_out.imm;
    assign out_illegal = w_out.illegal;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_inst_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_inst_decode_stage
// Directed and randomized stimulus; a negedge monitor compares DUT outputs
// against a queue-based reference model of the stage contents.
// -----------------------------------------------------------------------------
module tb_inst_decode_stage;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      in_inst   = 32'h0;
    logic [31:0]      in_pc     = 32'h0;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [6:0]       out_type;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [2:0]       out_funct3;
    logic [6:0]       out_funct7;
    logic [31:0]      out_imm;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    inst_decode_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_type    (out_type),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t             exp_q[$];
    int               n_cmp     = 0;
    int               n_bad     = 0;
    int               dut_deliv = 0;
    logic [CNT_W-1:0] m_cnt     = '0;

    // Immediate from the ISA bit-weight definitions, using plain integers.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t   e;
        longint v;
        e.pc  = pc;
        e.op  = w[6:0];
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.f3  = w[14:12];
        e.f7  = w[31:25];
        e.ill = 1'b0;
        v     = 0;
        case (w[6:0])
            7'h33: v = 0;
            7'h13: begin
                v = longint'(w[31:20]);
                if (v >= 2048) v = v - 4096;
            end
            7'h23: begin
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                if (v >= 2048) v = v - 4096;
            end
            7'h63: begin
                v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                if (v >= 4096) v = v - 8192;
            end
            7'h17: v = longint'(w[31:12]) * 4096;
            7'h6F: begin
                v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                if (v >= 1048576) v = v - 2097152;
            end
            default: e.ill = 1'b1;
        endcase
        e.imm = v[31:0];
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compare outputs with the model, then advance the model by the
    // effect of the coming rising edge (inputs are stable at negedge).
    always @(negedge clk) begin
        exp_t e;
        bit   hand;
        bit   acc;
        if (out_valid && out_ready) dut_deliv++;
        if (!rst_n) begin
            exp_q.delete();
            m_cnt = '0;
            chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
            chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
            chk("rst_illegal_cnt", 128'(illegal_cnt), 128'(16'h0));
        end else begin
            chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
            chk("in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
            chk("illegal_cnt", 128'(illegal_cnt), 128'(m_cnt));
            if (exp_q.size() > 0 && out_valid) begin
                e = exp_q[0];
                chk("bundle",
                    128'({out_pc, out_type, out_rd, out_rs1, out_rs2, out_funct3,
                          out_funct7, out_imm, out_illegal}),
                    128'({e.pc, e.op, e.rd, e.rs1, e.rs2, e.f3, e.f7, e.imm, e.ill}));
            end
            hand = (exp_q.size() > 0) && out_ready;
            acc  = in_valid && (exp_q.size() < 2) && !flush;
            if (hand && exp_q[0].ill && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (hand) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(ref_decode(in_inst, in_pc));
            end
        end
    end

    // Present one word and hold it until the stage takes it (bounded wait).
    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        bit done;
        int budget;
        done     = 1'b0;
        budget   = 60;
        in_valid = 1'b1;
        in_inst  = w;
        in_pc    = pc;
        while (!done) begin
            @(negedge clk);
            done = in_ready && !flush;
            @(posedge clk);
            #1;
            if (!done) begin
                budget--;
                if (budget == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL send_timeout: got in_ready stuck low expected accept pc=%0h", pc);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom();
        case ($urandom_range(0, 7))
            0: op = 7'h33;
            1: op = 7'h13;
            2: op = 7'h23;
            3: op = 7'h63;
            4: op = 7'h17;
            5: op = 7'h6F;
            6: op = 7'h03;
            default: op = r[6:0];
        endcase
        return {r[31:7], op};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit acc;

        // Reset
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_pc", 128'(out_pc), 128'(32'h0));
        chk("rst_out_type", 128'(out_type), 128'(7'h00));
        chk("rst_out_imm", 128'(out_imm), 128'(32'h0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        cycles(1);

        // ADDI x1,x0,5
        send(32'h00500093, 32'h0000_0100);
        chk("addi_valid", 128'(out_valid), 128'(1'b1));
        chk("addi_type", 128'(out_type), 128'(7'h13));
        chk("addi_rd", 128'(out_rd), 128'(5'd1));
        chk("addi_rs1", 128'(out_rs1), 128'(5'd0));
        chk("addi_imm", 128'(out_imm), 128'(32'h0000_0005));

        // BEQ / JAL / AUIPC back to back
        send(32'hFE000EE3, 32'h0000_0104);
        chk("beq_imm", 128'(out_imm), 128'(32'hFFFF_FFFC));
        send(32'h001000EF, 32'h0000_0108);
        chk("jal_imm", 128'(out_imm), 128'(32'h0000_0800));
        send(32'h12345117, 32'h0000_010C);
        chk("auipc_imm", 128'(out_imm), 128'(32'h1234_5000));

        // Illegal opcode three times
        for (int i = 0; i < 3; i++) begin
            send(32'h00000003, 32'h0000_0200 + 32'(i * 4));
            chk("illegal_flag", 128'(out_illegal), 128'(1'b1));
        end
        cycles(1);
        chk("illegal_cnt_3", 128'(illegal_cnt), 128'(16'd3));

        // Stall: four words offered with out_ready low
        cycles(2);
        d0 = dut_deliv;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(rand_word(), 32'h0000_1000 + 32'(i * 4));
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                chk("stall_in_ready", 128'(in_ready), 128'(1'b0));
                chk("stall_head_pc", 128'(out_pc), 128'(32'h0000_1000));
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        cycles(5);
        chk("stall_delivered", 128'(dut_deliv - d0), 128'(4));

        // Flush in state TWO with a word offered
        out_ready = 1'b0;
        send(32'h00100113, 32'h0000_2000);
        send(32'h00200193, 32'h0000_2004);
        chk("pre_flush_full", 128'(in_ready), 128'(1'b0));
        d0 = dut_deliv;
        in_valid = 1'b1;
        in_inst  = 32'h0AB00093;
        in_pc    = 32'h0000_0F00;
        flush    = 1'b1;
        cycles(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'(1'b0));
        chk("flush_in_ready", 128'(in_ready), 128'(1'b1));
        out_ready = 1'b1;
        cycles(4);
        chk("flush_nothing_out", 128'(dut_deliv - d0), 128'(0));

        // Randomized traffic with stalls and occasional flushes
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready && !flush;
            @(posedge clk);
            #1;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_inst  = rand_word();
                in_pc    = $urandom();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles(4);

        // Reset while full and stalled, then latency after release
        send(32'h00000003, 32'h0000_3000);
        cycles(1);
        out_ready = 1'b0;
        send(32'h00000003, 32'h0000_3004);
        send(32'h00500093, 32'h0000_3008);
        chk("pre_rst_full", 128'(in_ready), 128'(1'b0));
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 128'(out_valid), 128'(1'b0));
        chk("async_in_ready", 128'(in_ready), 128'(1'b1));
        chk("async_cnt", 128'(illegal_cnt), 128'(16'h0));
        chk("async_out_pc", 128'(out_pc), 128'(32'h0));
        chk("async_out_imm", 128'(out_imm), 128'(32'h0));
        chk("async_out_type", 128'(out_type), 128'(7'h00));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h12345117, 32'h0000_4000);
        chk("post_rst_valid", 128'(out_valid), 128'(1'b1));
        chk("post_rst_pc", 128'(out_pc), 128'(32'h0000_4000));
        cycles(2);

        // Saturation of the illegal counter
        for (int i = 0; i < 65540; i++) send(32'h00000003, 32'(i * 4));
        cycles(3);
        chk("cnt_saturated", 128'(illegal_cnt), 128'(16'hFFFF));
        send(32'h00000003, 32'h0000_5000);
        cycles(2);
        chk("cnt_stays_max", 128'(illegal_cnt), 128'(16'hFFFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Pipelined RV32I instruction decode stage. Accepts raw 32-bit instruction words with their PC from the fetch side over a valid/ready handshake. Splits each word into the R/I/S/B/U/J field layouts defined in `instructions_pkg` and produces a sign-extended 32-bit immediate plus an illegal-opcode flag. Sits directly downstream of instruction fetch and feeds the execute stage, with a two-entry skid buffer so both sides can stall independently at full throughput.

## Interface
- `XLEN`, default 32: datapath and PC width; only 32 is supported.
- `CNT_W`, default 16: width of the illegal-instruction counter.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `flush`  in  1  synchronous pipeline flush (branch redirect).
- `in_valid`  in  1  fetch word valid.
- `in_ready`  out  1  stage can accept a word.
- `in_inst`  in  32  raw instruction (`instruction_t`).
- `in_pc`  in  XLEN  PC of `in_inst`.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  execute accepts the bundle.
- `out_pc`  out  XLEN  PC of the bundle.
- `out_type`  out  7  opcode (`inst_type_e`).
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register indices, taken raw from bits [11:7], [19:15], [24:20].
- `out_funct3`  out  3  bits [14:12].
- `out_funct7`  out  7  bits [31:25].
- `out_imm`  out  XLEN  sign-extended immediate.
- `out_illegal`  out  1  opcode is not in `inst_type_e`.
- `illegal_cnt`  out  CNT_W  saturating count of illegal bundles handed off.

## Operation
- **Immediate selection by opcode:**
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U (AUIPC): {inst[31:12], 12'h000}.
  - J (JAL): sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - R and illegal: 0.
- **Illegal opcodes:** `out_illegal`=1 for any opcode not in `inst_type_e`. The bundle still flows; other fields are passed raw.
- **Input accept:** a word is accepted when `in_valid && in_ready && !flush`.
- **Buffer states:** EMPTY, ONE (output register valid), TWO (output register and skid register valid).
  - EMPTY→ONE on accept.
  - ONE→TWO on accept without output handoff.
  - ONE→EMPTY on handoff without accept.
  - TWO→ONE on handoff; the skid entry moves to the output register.
  - ONE holds on simultaneous accept and handoff.
- **`in_ready`** = state != TWO. It is registered, so it has no combinational path from `out_ready`.
- **Order:** strict FIFO order is preserved. The skid entry never overtakes the output register.
- **`flush`:**
  - Forces EMPTY on the next edge.
  - Drops any word presented in the same cycle.
  - Overrides a simultaneous handoff: the bundle counts as consumed if `out_ready` was high, but nothing else survives.
- **`illegal_cnt`:**
  - Increments on each handoff (`out_valid && out_ready`) with `out_illegal`=1.
  - Saturates at all-ones.
  - Is not cleared by `flush`.

## Timing
- **Reset values:**
  - `out_valid`=0, `in_ready`=1, `illegal_cnt`=0.
  - All data outputs 0; `out_type` = 7'h00.
- **Latency:** a word accepted at edge N is on the outputs after edge N, i.e. 1 cycle.
- **Throughput:** 1 word/cycle sustained while `out_ready`=1.
- **Stability:** outputs hold stable while `out_valid && !out_ready`.
- **Stall:** after `out_ready` drops, at most 2 words are held. `in_ready` falls the cycle after the second word is accepted.
- **Reset mid-operation:** both entries are discarded immediately on `rst_n` falling, and the counter clears.

## Structure
- **Add to `instructions_pkg`:**
  - `decoded_t` packed struct: pc, type, rd, rs1, rs2, funct3, funct7, imm, illegal.
  - `function automatic decode(instruction_t)` returning `decoded_t`. It is combinational and shared with the scoreboard reference model.
- **Sub-module `inst_skid_buffer`:**
  - Parameterized by payload width.
  - Contains the two-entry state machine and flush logic.
  - The decode stage instantiates it with the `decoded_t` payload; decode happens before the buffer.

## Test plan
- ADDI x1,x0,5: `in_inst`=0x00500093 → one cycle later `out_type`=i_type, `out_rd`=1, `out_rs1`=0, `out_imm`=0x00000005.
- BEQ x0,x0,-4 (0xFE000EE3), then JAL x1,+2048 (0x001000EF), then AUIPC x2,0x12345 (0x12345117), back-to-back → `out_imm` = 0xFFFFFFFC, 0x00000800, 0x12345000 on consecutive cycles.
- Opcode 0x03 word 0x00000003 handed off three times → `out_illegal`=1 each time, `illegal_cnt`=3. Preload `illegal_cnt` to 0xFFFF → it stays at 0xFFFF.
- `out_ready`=0 with 4 words offered on consecutive cycles → 2 accepted, `in_ready`=0 from the third cycle. Release `out_ready` → words emerge in order, all 4 delivered.
- State TWO, assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the offered word is never seen on the output.
- Drop `rst_n` while in state TWO mid-stall → outputs return to reset values asynchronously. After release, the first accepted word appears with latency 1.
